// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared width constants and sum type for the pipelined adder
package adder_pkg;

    localparam int WIDTH = 20;
    localparam int SPLIT = 10;

    typedef logic [WIDTH-1:0] sum_t;

endpackage

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - N-bit ripple add with carry-in and carry-out
module adder_slice #(
    parameter int N = 10
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] total;

    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
        sum   = total[N-1:0];
        cout  = total[N];
    end

endmodule

// File: rtl/adder.sv
// rtl/adder.sv - two-stage pipelined unsigned adder with carry chain cut at SPLIT
module adder #(
    parameter int WIDTH = adder_pkg::WIDTH,
    parameter int SPLIT = adder_pkg::SPLIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] c,
    output logic             cout
);

    localparam int HI = WIDTH - SPLIT;

    logic [SPLIT-1:0] s_lo_q, s_lo_d;
    logic             k1_q, k1_d;
    logic [HI-1:0]    a_hi_q, a_hi_d;
    logic [HI-1:0]    b_hi_q, b_hi_d;
    logic             v1_q, v1_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             cout_q, cout_d;
    logic             out_valid_q, out_valid_d;

    logic [SPLIT-1:0] lo_sum;
    logic             lo_cout;
    logic [HI-1:0]    hi_sum;
    logic             hi_cout;

    adder_slice #(.N(SPLIT)) u_lo (
        .a    (a[SPLIT-1:0]),
        .b    (b[SPLIT-1:0]),
        .cin  (1'b0),
        .sum  (lo_sum),
        .cout (lo_cout)
    );

    // Upper half finishes in stage 2 using the carry registered from the low half.
    adder_slice #(.N(HI)) u_hi (
        .a    (a_hi_q),
        .b    (b_hi_q),
        .cin  (k1_q),
        .sum  (hi_sum),
        .cout (hi_cout)
    );

    always_comb begin
        s_lo_d      = lo_sum;
        k1_d        = lo_cout;
        a_hi_d      = a[WIDTH-1:SPLIT];
        b_hi_d      = b[WIDTH-1:SPLIT];
        v1_d        = in_valid;
        c_d         = {hi_sum, s_lo_q};
        cout_d      = hi_cout;
        out_valid_d = v1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_lo_q      <= '0;
            k1_q        <= 1'b0;
            a_hi_q      <= '0;
            b_hi_q      <= '0;
            v1_q        <= 1'b0;
            c_q         <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s_lo_q      <= s_lo_d;
            k1_q        <= k1_d;
            a_hi_q      <= a_hi_d;
            b_hi_q      <= b_hi_d;
            v1_q        <= v1_d;
            c_q         <= c_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_adder.sv
// tb/tb_adder.sv - scoreboard bench for the pipelined adder against an arithmetic model
module tb_adder;
    import adder_pkg::*;

    typedef struct {
        sum_t c;
        logic cout;
        int   cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    sum_t a = '0;
    sum_t b = '0;
    logic out_valid;
    sum_t c;
    logic cout;

    exp_t exp_q[$];
    int   cyc = 0;
    logic rst_at_edge = 1'b1;
    int   total = 0;
    int   bad = 0;

    adder #(.WIDTH(WIDTH), .SPLIT(SPLIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .c         (c),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Model: a sampled valid pair yields (a+b) mod 2^WIDTH and the overflow bit, two cycles on.
    task automatic send(input logic v, input sum_t x, input sum_t y);
        logic [WIDTH:0] s;
        exp_t e;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = v;
        a        = x;
        b        = y;
        if (v) begin
            s = {1'b0, x} + {1'b0, y};
            e.c    = s[WIDTH-1:0];
            e.cout = s[WIDTH];
            e.cyc  = cyc + 2;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst      = 1'b1;
            in_valid = 1'b1;
            a        = sum_t'($urandom);
            b        = sum_t'($urandom);
            exp_q.delete();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, sum_t'($urandom), sum_t'($urandom));
    endtask

    always @(negedge clk) begin
        if (rst_at_edge) begin
            chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
            chk("reset_c", {12'b0, c}, 32'd0);
            chk("reset_cout", {31'b0, cout}, 32'd0);
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("missing_out_valid", 32'd0, 32'd1);
                void'(exp_q.pop_front());
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("latency_cycle", cyc, e.cyc);
                    chk("sum_c", {12'b0, c}, {12'b0, e.c});
                    chk("sum_cout", {31'b0, cout}, {31'b0, e.cout});
                end
            end
        end
    end

    initial begin
        do_reset(3);

        send(1'b1, 20'd10, 20'd20);
        send(1'b1, 20'd15, 20'd2);
        send(1'b1, 20'd32, 20'd1);
        send(1'b1, 20'd22, 20'd17);
        send(1'b1, 20'd8,  20'd5);
        send(1'b1, 20'd4,  20'd87);

        send(1'b1, 20'h003FF, 20'h00001);
        send(1'b1, 20'hFFFFF, 20'h00001);
        send(1'b1, 20'hFFFFF, 20'hFFFFF);
        idle(1);

        send(1'b1, sum_t'($urandom), sum_t'($urandom));
        send(1'b0, sum_t'($urandom), sum_t'($urandom));
        send(1'b1, sum_t'($urandom), sum_t'($urandom));
        send(1'b1, sum_t'($urandom), sum_t'($urandom));
        send(1'b0, sum_t'($urandom), sum_t'($urandom));
        idle(3);

        send(1'b1, 20'd5, 20'd6);
        do_reset(2);

        send(1'b1, 20'd0, 20'd0);
        idle(3);

        for (int i = 0; i < 300; i++) begin
            logic v;
            sum_t x, y;
            v = ($urandom_range(0, 3) != 0);
            x = sum_t'($urandom);
            y = sum_t'($urandom);
            case ($urandom_range(0, 7))
                0: x = '1;
                1: begin x[SPLIT-1:0] = '1; y[SPLIT-1:0] = '1; end
                2: y = '0;
                default: ;
            endcase
            send(v, x, y);
        end
        idle(4);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder.md
# adder

Pipelined unsigned 20-bit adder: registers operands `a` and `b`, returns `c = a + b` modulo 2^20 plus a carry-out flag, two clock cycles later. It is a leaf arithmetic block in the datapath, used wherever a registered sum with fixed latency is needed. A `valid` strobe travels alongside the data so consumers know which output cycles carry a real result.

## Interface
Parameters:
- `WIDTH`, 20, operand and result width in bits.
- `SPLIT`, 10, bit position where the carry chain is cut between pipeline stages; legal range 1..WIDTH-1.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  `a`/`b` hold a new operand pair this cycle.
- `a`  input  WIDTH  unsigned operand A.
- `b`  input  WIDTH  unsigned operand B.
- `out_valid`  output  1  `c`/`cout` hold a result this cycle.
- `c`  output  WIDTH  sum `(a + b) mod 2^WIDTH`.
- `cout`  output  1  carry out of bit WIDTH-1 (unsigned overflow).

## Operation
- Stage 1 (first edge after sample): register low sum `s_lo = a[SPLIT-1:0] + b[SPLIT-1:0]` (SPLIT bits plus carry `k1`), and the upper operand halves `a[WIDTH-1:SPLIT]`, `b[WIDTH-1:SPLIT]`; register `v1 = in_valid`.
- Stage 2 (second edge): `c[WIDTH-1:SPLIT] = a_hi + b_hi + k1`, `c[SPLIT-1:0] = s_lo` registered, `cout` = carry out of the upper addition; `out_valid = v1`.
- Arithmetic is unsigned; no saturation; overflow wraps modulo 2^WIDTH and is reported only via `cout`.
- No back-pressure: the pipeline accepts a new pair every cycle; each accepted pair produces exactly one result.
- Data registers load every cycle regardless of `in_valid`; `c`/`cout` are meaningful only when `out_valid = 1`.
- `c` is purely a function of the sampled pair; there is no accumulation across pairs.

## Timing
- Latency: 2 cycles. A pair sampled at edge N appears on `c`/`cout` with `out_valid = 1` after edge N+2.
- Throughput: 1 result per cycle.
- Reset: while `rst` is high at an edge, all pipeline registers clear: `c = 0`, `cout = 0`, `out_valid = 0`, `v1 = 0`. Reset wins over a simultaneous `in_valid`.
- Reset mid-operation: in-flight pairs are dropped and produce no `out_valid` pulse. The first pair sampled at the edge after `rst` is deasserted appears 2 edges later.
- Back-to-back pairs with `in_valid` toggling produce the same `out_valid` pattern delayed by exactly 2 cycles.
- Outputs come directly from registers; there is no combinational path from input to output.

## Structure
- Shared package `adder_pkg`: `WIDTH` and `SPLIT` default constants and a `sum_t` typedef (`logic [WIDTH-1:0]`).
- One sub-module, `adder_slice`: an N-bit ripple add with carry-in and carry-out. It is instantiated twice: the low slice with carry-in 0, and the high slice with carry-in `k1`.
- The top level holds only the stage registers, the valid pipeline and the reset logic.

## Test plan
- After reset, drive `in_valid=1` with (10,20), (15,2), (32,1), (22,17), (8,5), (4,87) on consecutive cycles. Required: `c` = 30, 17, 33, 39, 13, 91 on cycles 2–7, with `cout=0` and `out_valid=1` throughout.
- Carry crossing the split: (0x003FF, 0x00001) -> `c=0x00400`, `cout=0`, which exercises the `k1` propagation.
- Wrap-around: (0xFFFFF, 0x00001) -> `c=0x00000`, `cout=1`. Also (0xFFFFF, 0xFFFFF) -> `c=0xFFFFE`, `cout=1`.
- Valid gaps: `in_valid` pattern 1,0,1,1,0 -> `out_valid` pattern 1,0,1,1,0 starting 2 cycles later, with matching sums.
- Reset mid-flight: send (5,6) then assert `rst` at the next edge. Required: no `out_valid` pulse for (5,6), and `c=0`, `cout=0` while in reset.
- Zero operands: (0,0) -> `c=0`, `cout=0`, `out_valid=1` exactly 2 cycles after the sample.
